pipe_hazard_ctrl: RTL

- Pipeline sequencing controller for the 16-bit stack CPU.
- Drives flush and hold controls for the PC, IF/ID and ID/EX pipeline registers.
- Arbitrates between three request sources:
  - jump redirects from EX;
  - multi-cycle data-memory waits from EX;
  - operand hazards from ID.
- Captures and delivers the redirect target to the PC.
- Flags data-memory timeouts.

---
 rtl/pipe_hazard_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline flush/hold sequencing for the 16-bit stack CPU
// Optional perf counters (stall_cnt_o, flush_cnt_o) enabled by PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int ADDR_WIDTH   = 13,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  jump_req_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  mem_req_i,
  input  logic                  mem_ready_i,
  input  logic                  hazard_i,
  input  logic                  clear_i,
  output logic                  if_id_flush_o,
  output logic                  id_ex_flush_o,
  output logic                  hold_pc_o,
  output logic                  hold_if_id_o,
  output logic                  hold_id_ex_o,
  output logic                  pc_load_o,
  output logic [ADDR_WIDTH-1:0] jump_addr_o,
  output logic                  mem_timeout_o,
  output logic [1:0]            state_o
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o,
  output logic [CNT_WIDTH-1:0]  flush_cnt_o
`endif
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 3 || MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 ||
      CNT_WIDTH < 1) begin : g_bad_params
    $error("pipe_hazard_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] FLUSH_INIT  = 2'(FLUSH_CYCLES);
  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  state_t     state_q;
  logic [1:0] flush_cnt_q;
  logic [7:0] wait_cnt_q;
  logic       mem_stall;
  logic       timeout_hit;
  logic       jump_accept;

  assign mem_stall   = mem_req_i && !mem_ready_i;
  assign jump_accept = (state_q == RUN) && jump_req_i;
  assign timeout_hit = (state_q == MEM_WAIT) && !mem_ready_i && (wait_cnt_q == TIMEOUT_LIM);
  assign state_o     = state_q;

  always_comb begin
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    hold_pc_o     = 1'b0;
    hold_if_id_o  = 1'b0;
    hold_id_ex_o  = 1'b0;
    case (state_q)
      RUN: begin
        if (jump_req_i) begin
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end else if (mem_stall) begin
          hold_pc_o    = 1'b1;
          hold_if_id_o = 1'b1;
          hold_id_ex_o = 1'b1;
        end else if (hazard_i) begin
          // Freeze fetch/decode and push a bubble into EX.
          hold_pc_o     = 1'b1;
          hold_if_id_o  = 1'b1;
          id_ex_flush_o = 1'b1;
        end
      end
      FLUSH: begin
        if_id_flush_o = 1'b1;
        id_ex_flush_o = 1'b1;
      end
      MEM_WAIT: begin
        hold_pc_o    = !mem_ready_i;
        hold_if_id_o = !mem_ready_i;
        hold_id_ex_o = !mem_ready_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      flush_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      pc_load_o     <= 1'b0;
      jump_addr_o   <= '0;
      mem_timeout_o <= 1'b0;
    end else begin
      pc_load_o <= 1'b0;
      // A timeout in the same cycle as clear_i keeps the error set.
      if (timeout_hit) begin
        mem_timeout_o <= 1'b1;
      end else if (clear_i) begin
        mem_timeout_o <= 1'b0;
      end
      case (state_q)
        RUN: begin
          if (jump_req_i) begin
            jump_addr_o <= jump_addr_i;
            pc_load_o   <= 1'b1;
            flush_cnt_q <= FLUSH_INIT;
            state_q     <= FLUSH;
          end else if (mem_stall) begin
            wait_cnt_q <= 8'd1;
            state_q    <= MEM_WAIT;
          end
        end
        FLUSH: begin
          flush_cnt_q <= flush_cnt_q - 2'd1;
          if (flush_cnt_q == 2'd1) begin
            state_q <= RUN;
          end
        end
        MEM_WAIT: begin
          if (mem_ready_i || timeout_hit) begin
            state_q <= RUN;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else if (clear_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (hold_pc_o && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
      if (jump_accept && (flush_cnt_o != '1)) begin
        flush_cnt_o <= flush_cnt_o + 1'b1;
      end
    end
  end
`endif

endmodule
